// File: rtl/core_bus_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_ram_pkg
// Purpose  : Core bus word/pointer/byte-enable types and the address-window helper.
// Revision : 1.0 - initial release
// ============================================================================
package core_bus_ram_pkg;

    localparam int c_WORD_BITS = 32;
    localparam int c_PTR_BITS  = 30;
    localparam int c_BE_BITS   = c_WORD_BITS / 8;

    typedef logic [c_WORD_BITS-1:0] word_t;
    typedef logic [c_PTR_BITS-1:0]  ptr_t;
    typedef logic [c_BE_BITS-1:0]   be_t;

    typedef struct packed {
        ptr_t  addr;
        logic  write;
        word_t data;
        be_t   be;
    } bus_req_t;

    // True when the pointer bits above the RAM index select this slave.
    function automatic logic f_in_window(input ptr_t addr, input int unsigned addr_bits,
                                         input ptr_t base);
        return (addr >> addr_bits) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_bus_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_ram_if
// Purpose  : Start/ready memory bus between an initiator and a memory slave.
// Revision : 1.0 - initial release
// ============================================================================
interface core_bus_ram_if;
    import core_bus_ram_pkg::*;

    logic  bus_start;
    ptr_t  bus_addr;
    logic  bus_write;
    word_t bus_data_wr;
    be_t   bus_data_be;
    logic  bus_ready;
    word_t bus_data_rd;

    modport master (
        output bus_start, bus_addr, bus_write, bus_data_wr, bus_data_be,
        input  bus_ready, bus_data_rd
    );

    modport slave (
        input  bus_start, bus_addr, bus_write, bus_data_wr, bus_data_be,
        output bus_ready, bus_data_rd
    );

endinterface
`default_nettype wire

// File: rtl/core_bus_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_ram_array
// Purpose  : Single-port synchronous RAM, byte write enables, registered
//            read returning the old word on a same-address write.
// Revision : 1.0 - initial release
// ============================================================================
module core_bus_ram_array
    import core_bus_ram_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  wire logic                 clk,
    input  wire logic                 i_en,
    input  wire logic                 i_we,
    input  wire be_t                  i_be,
    input  wire logic [ADDR_BITS-1:0] i_addr,
    input  wire word_t                i_wdata,
    output wire word_t                o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_BITS;

    // One narrow array per lane keeps each lane a plain block-RAM template.
    for (genvar gi = 0; gi < c_BE_BITS; gi++) begin : g_lane
        logic [7:0] r_mem [c_DEPTH];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_en) begin
                if (i_we && i_be[gi]) begin
                    r_mem[i_addr] <= i_wdata[8*gi +: 8];
                end
                r_q <= r_mem[i_addr];
            end
        end

        assign o_rdata[8*gi +: 8] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/core_bus_ram.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_ram
// Purpose  : Boot/scratch memory slave on the core bus with programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module core_bus_ram
    import core_bus_ram_pkg::*;
#(
    parameter int   ADDR_BITS   = 12,
    parameter ptr_t BASE        = '0,
    parameter int   WAIT_STATES = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    core_bus_ram_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] c_WAIT_INIT   = 4'(WAIT_STATES);
    localparam state_t     c_START_STATE = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_capture;
    bus_req_t   r_req;
    logic       r_rd_zero;
    logic       w_access;
    logic       w_in_window;
    word_t      w_array_rd;

    assign w_in_window = f_in_window(r_req.addr, ADDR_BITS, BASE);
    assign w_access    = (r_state == S_ACCESS);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.bus_start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_START_STATE;
                    w_cnt_nxt   = c_WAIT_INIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                // A start in the ready cycle is taken immediately (back-to-back).
                if (bus.bus_start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_START_STATE;
                    w_cnt_nxt   = c_WAIT_INIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd_zero <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_access) begin
                r_rd_zero <= !w_in_window;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_req.addr  <= bus.bus_addr;
            r_req.write <= bus.bus_write;
            r_req.data  <= bus.bus_data_wr;
            r_req.be    <= bus.bus_data_be;
        end
    end

    // Out-of-window requests never touch the array, so no write can leak through.
    core_bus_ram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .i_en    (w_access && w_in_window),
        .i_we    (r_req.write),
        .i_be    (r_req.be),
        .i_addr  (r_req.addr[ADDR_BITS-1:0]),
        .i_wdata (r_req.data),
        .o_rdata (w_array_rd)
    );

    assign bus.bus_ready   = (r_state == S_RESP);
    assign bus.bus_data_rd = r_rd_zero ? '0 : w_array_rd;

endmodule
`default_nettype wire

// File: tb/tb_core_bus_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_bus_ram
// Purpose  : Bench for core_bus_ram: a one-wait-state and a zero-wait-state
//            build against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_bus_ram;
    import core_bus_ram_pkg::*;

    localparam int c_WS_A = 1;
    localparam int c_WS_B = 0;

    typedef struct packed {
        ptr_t        addr;
        logic        write;
        word_t       data;
        be_t         be;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    // Model state, index 0 = one-wait-state build, 1 = zero-wait-state build
    word_t       mem_m [2][4096];
    bit          known [2][4096];
    word_t       last_rd [2];
    bit          last_known [2];
    exp_t        pend [2][32];
    logic [4:0]  ph [2];
    logic [4:0]  pt [2];

    core_bus_ram_if bus_a ();
    core_bus_ram_if bus_b ();

    core_bus_ram #(.ADDR_BITS(12), .BASE(30'd0), .WAIT_STATES(c_WS_A)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    core_bus_ram #(.ADDR_BITS(12), .BASE(30'd0), .WAIT_STATES(c_WS_B)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws(input int k);
        return (k == 0) ? c_WS_A : c_WS_B;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic s, input logic w, input ptr_t a,
                         input word_t d, input be_t be);
        if (k == 0) begin
            bus_a.bus_start = s; bus_a.bus_write = w; bus_a.bus_addr = a;
            bus_a.bus_data_wr = d; bus_a.bus_data_be = be;
        end else begin
            bus_b.bus_start = s; bus_b.bus_write = w; bus_b.bus_addr = a;
            bus_b.bus_data_wr = d; bus_b.bus_data_be = be;
        end
    endtask

    task automatic drive_idle(input int k);
        drive(k, 1'b0, 1'($urandom), ptr_t'($urandom), $urandom, be_t'($urandom));
    endtask

    function automatic logic get_ready(input int k);
        return (k == 0) ? bus_a.bus_ready : bus_b.bus_ready;
    endfunction

    function automatic word_t get_rd(input int k);
        return (k == 0) ? bus_a.bus_data_rd : bus_b.bus_data_rd;
    endfunction

    // Per-cycle compare: ready exactly on the due cycle, read data held between completions.
    task automatic compare_port(input int k, input logic rdy, input word_t rd);
        exp_t       e;
        bit         due_now;
        bit         inwin;
        logic [11:0] idx;
        due_now = 1'b0;
        if (!rst_n) begin
            ph[k] = pt[k];
            last_rd[k] = '0;
            last_known[k] = 1'b1;
            check($sformatf("p%0d_reset_ready", k), {31'd0, rdy}, 32'd0);
            check($sformatf("p%0d_reset_rdata", k), rd, 32'd0);
            return;
        end
        while (pt[k] != ph[k] && pend[k][ph[k]].due < cyc) ph[k] = ph[k] + 5'd1;
        if (pt[k] != ph[k] && pend[k][ph[k]].due == cyc) due_now = 1'b1;
        check($sformatf("p%0d_ready", k), {31'd0, rdy}, {31'd0, due_now});
        if (due_now) begin
            e = pend[k][ph[k]];
            ph[k] = ph[k] + 5'd1;
            inwin = (e.addr < 30'h1000);
            idx = e.addr[11:0];
            if (!inwin) begin
                last_rd[k] = '0;
                last_known[k] = 1'b1;
            end else begin
                last_rd[k] = mem_m[k][idx];
                last_known[k] = known[k][idx];
                if (e.write) begin
                    for (int b = 0; b < 4; b++) begin
                        if (e.be[b]) mem_m[k][idx][8*b +: 8] = e.data[8*b +: 8];
                    end
                    if (e.be == 4'hF) known[k][idx] = 1'b1;
                end
            end
        end
        if (last_known[k]) check($sformatf("p%0d_rdata", k), rd, last_rd[k]);
    endtask

    always @(negedge clk) begin
        compare_port(0, bus_a.bus_ready, bus_a.bus_data_rd);
        compare_port(1, bus_b.bus_ready, bus_b.bus_data_rd);
    end

    // Issues one request at the current falling edge; returns at the falling edge showing ready.
    task automatic op(input int k, input logic w, input ptr_t a, input word_t d, input be_t be,
                      input bit gap, input bit inject, output word_t rd_out);
        int lat;
        if (gap) begin
            drive_idle(k);
            @(negedge clk);
        end
        drive(k, 1'b1, w, a, d, be);
        pend[k][pt[k]] = '{addr: a, write: w, data: d, be: be, due: cyc + 2 + ws(k)};
        pt[k] = pt[k] + 5'd1;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (inject && lat == 1)
                drive(k, 1'b1, 1'($urandom), ptr_t'($urandom_range(0, 63)), $urandom, be_t'($urandom));
            else
                drive_idle(k);
            if (get_ready(k)) break;
        end
        check($sformatf("p%0d_latency", k), lat, 2 + ws(k));
        rd_out = get_rd(k);
    endtask

    task automatic random_op(input int k);
        ptr_t  a;
        word_t rd;
        if ($urandom_range(0, 9) == 0)
            a = {18'($urandom_range(1, 262143)), 12'($urandom_range(0, 63))};
        else
            a = ptr_t'($urandom_range(0, 63));
        op(k, 1'($urandom), a, $urandom, be_t'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t rd;
        for (int k = 0; k < 2; k++) begin
            ph[k] = '0; pt[k] = '0; last_rd[k] = '0; last_known[k] = 1'b1;
        end
        drive_idle(0);
        drive_idle(1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 64; a++)
                op(p, 1'b1, ptr_t'(a), $urandom, 4'hF, 1'($urandom_range(0, 1)), 1'b0, rd);

        op(0, 1'b1, 30'h010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, rd);
        op(0, 1'b0, 30'h010, 32'h0, 4'h0, 1'b1, 1'b0, rd);
        check("deadbeef_read", rd, 32'hDEADBEEF);

        op(0, 1'b1, 30'h020, 32'h11223344, 4'hF, 1'b1, 1'b0, rd);
        op(0, 1'b1, 30'h020, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, rd);
        check("partial_write_old_data", rd, 32'h11223344);
        op(0, 1'b0, 30'h020, 32'h0, 4'h0, 1'b1, 1'b0, rd);
        check("partial_merge", rd, 32'h11BB33DD);

        op(0, 1'b1, 30'h010, 32'h12345678, 4'h0, 1'b1, 1'b0, rd);
        op(0, 1'b0, 30'h010, 32'h0, 4'h0, 1'b0, 1'b0, rd);
        check("be0_noop", rd, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) begin
            op(0, 1'b0, ptr_t'(8 + 4 * i), $urandom, be_t'($urandom), (i == 0), 1'b0, rd);
            if (i == 2) check("b2b_read_0x010", rd, 32'hDEADBEEF);
        end

        op(0, 1'b1, 30'h000, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, rd);
        op(0, 1'b1, 30'h1000, 32'hCAFEBABE, 4'hF, 1'b1, 1'b0, rd);
        op(0, 1'b0, 30'h1000, 32'h0, 4'h0, 1'b1, 1'b0, rd);
        check("oow_read", rd, 32'h0);
        op(0, 1'b0, 30'h000, 32'h0, 4'h0, 1'b1, 1'b0, rd);
        check("oow_addr0_unchanged", rd, 32'h0BADF00D);

        op(0, 1'b1, 30'h030, 32'h0, 4'hF, 1'b1, 1'b0, rd);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 30'h030, 32'hFFFFFFFF, 4'hF);
        pend[0][pt[0]] = '{addr: 30'h030, write: 1'b1, data: 32'hFFFFFFFF, be: 4'hF,
                           due: cyc + 2 + c_WS_A};
        pt[0] = pt[0] + 5'd1;
        @(negedge clk);
        drive_idle(0);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        op(0, 1'b0, 30'h030, 32'h0, 4'h0, 1'b1, 1'b0, rd);
        check("abort_not_committed", rd, 32'h0);

        op(0, 1'b1, 30'h031, 32'h0F0F0F0F, 4'hF, 1'b1, 1'b1, rd);
        op(1, 1'b1, 30'h005, 32'h5555AAAA, 4'hF, 1'b1, 1'b1, rd);
        op(1, 1'b0, 30'h005, 32'h0, 4'h0, 1'b1, 1'b1, rd);
        check("ws0_inject_read", rd, 32'h5555AAAA);

        for (int n = 0; n < 300; n++) random_op(n % 2);

        repeat (6) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
